block_cost_engine: RTL

//  Row-serial matching-cost engine for the stereo pipeline. Computes the SSD or SAD between one BLKxBLK window

---
 rtl/stereo_pkg.sv | 27 ++
 rtl/ssd_row_reducer.sv | 35 +++
 rtl/block_cost_engine.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stereo_pkg.sv
// Shared types and width helpers for the stereo matching-cost blocks.
package stereo_pkg;

    typedef enum logic {
        COST_SSD = 1'b0,
        COST_SAD = 1'b1
    } cost_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROW   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } engine_state_t;

    function automatic int off_w(input int blk);
        return $clog2(blk + 1);
    endfunction

    // Wide enough for BLK*BLK squared full-scale differences.
    function automatic int cost_w(input int blk, input int pix_w);
        longint pmax;
        pmax = (longint'(1) << pix_w) - 1;
        return $clog2(longint'(blk) * blk * pmax * pmax + 1);
    endfunction

endpackage

// File: rtl/ssd_row_reducer.sv
// Combinational row cost: per-pixel |l-r|, optionally squared, summed across the row window.
module ssd_row_reducer
    import stereo_pkg::*;
#(
    parameter int BLK   = 6,
    parameter int PIX_W = 8,
    localparam int COST_W = cost_w(BLK, PIX_W)
) (
    input  logic [BLK*PIX_W-1:0] left_row,
    input  logic [BLK*PIX_W-1:0] right_row,
    input  cost_mode_t           mode,
    output logic [COST_W-1:0]    row_cost
);

    logic [PIX_W-1:0]  l_pix;
    logic [PIX_W-1:0]  r_pix;
    logic [PIX_W-1:0]  diff;
    logic [COST_W-1:0] term;

    always_comb begin
        row_cost = '0;
        l_pix    = '0;
        r_pix    = '0;
        diff     = '0;
        term     = '0;
        for (int c = 0; c < BLK; c++) begin
            l_pix = left_row[(BLK-1-c)*PIX_W +: PIX_W];
            r_pix = right_row[(BLK-1-c)*PIX_W +: PIX_W];
            diff  = (l_pix > r_pix) ? (l_pix - r_pix) : (r_pix - l_pix);
            term  = (mode == COST_SSD) ? COST_W'(diff) * COST_W'(diff) : COST_W'(diff);
            row_cost = row_cost + term;
        end
    end

endmodule

// File: rtl/block_cost_engine.sv
// Row-serial SSD/SAD window cost engine with valid/ready on request and result.
// Optional early exit on threshold: define BLOCK_COST_EARLY_EXIT_EN.
module block_cost_engine
    import stereo_pkg::*;
#(
    parameter int BLK   = 6,
    parameter int PIX_W = 8,
    localparam int OFF_W  = off_w(BLK),
    localparam int COST_W = cost_w(BLK, PIX_W)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            valid_in,
    output logic                            ready_out,
    input  cost_mode_t                      mode_in,
    input  logic [OFF_W-1:0]                left_off_in,
    input  logic [OFF_W-1:0]                right_off_in,
    input  logic [COST_W-1:0]               thresh_in,
    input  logic [BLK-1:0][BLK*PIX_W-1:0]   left_front_in,
    input  logic [BLK-1:0][BLK*PIX_W-1:0]   left_back_in,
    input  logic [BLK-1:0][BLK*PIX_W-1:0]   right_front_in,
    input  logic [BLK-1:0][BLK*PIX_W-1:0]   right_back_in,
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic [COST_W-1:0]               cost_out,
    output logic                            early_out,
    output engine_state_t                   state_dbg
);

    localparam int ROW_W = BLK * PIX_W;
    localparam int CNT_W = $clog2(BLK);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, holds its payload stable until that edge.
    engine_state_t                 state, state_next;
    logic [CNT_W-1:0]              row_cnt;
    logic [COST_W-1:0]             row_sum, acc, acc_next, row_cost;
    logic                          early_q, exit_hit, accept;
    cost_mode_t                    mode_q;
    logic [OFF_W-1:0]              loff_q, roff_q;
    logic [BLK-1:0][ROW_W-1:0]     lf_q, lb_q, rf_q, rb_q;
    logic [ROW_W-1:0]              left_win, right_win;

    // Pixel 0 is at the MSBs, so shifting left by off pixels brings column off to the top.
    function automatic logic [ROW_W-1:0] window(input logic [ROW_W-1:0] front,
                                                input logic [ROW_W-1:0] back,
                                                input logic [OFF_W-1:0] off);
        logic [2*ROW_W-1:0] cat;
        logic [OFF_W-1:0]   o;
        o   = (off > OFF_W'(BLK)) ? OFF_W'(BLK) : off;
        cat = {front, back} << (o * PIX_W);
        return cat[2*ROW_W-1 -: ROW_W];
    endfunction

    assign accept    = valid_in && (state == ST_IDLE);
    assign left_win  = window(lf_q[row_cnt], lb_q[row_cnt], loff_q);
    assign right_win = window(rf_q[row_cnt], rb_q[row_cnt], roff_q);
    assign acc_next  = acc + row_sum;

    ssd_row_reducer #(.BLK(BLK), .PIX_W(PIX_W)) u_reducer (
        .left_row  (left_win),
        .right_row (right_win),
        .mode      (mode_q),
        .row_cost  (row_cost)
    );

`ifdef BLOCK_COST_EARLY_EXIT_EN
    logic [COST_W-1:0] thresh_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)     thresh_q <= '0;
        else if (accept) thresh_q <= thresh_in;
    end

    // The first ROW cycle adds the cleared row_sum, which is not a real row contribution.
    assign exit_hit = ((state == ST_ROW && row_cnt != '0) || state == ST_DRAIN)
                      && (acc_next > thresh_q);
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh_in;
    assign exit_hit      = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (valid_in) state_next = ST_ROW;
            ST_ROW: begin
                if (exit_hit)                         state_next = ST_DONE;
                else if (row_cnt == CNT_W'(BLK - 1))  state_next = ST_DRAIN;
            end
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  if (ready_in) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state == ST_IDLE);
        valid_out = (state == ST_DONE);
        cost_out  = (state == ST_DONE) ? acc : '0;
        early_out = (state == ST_DONE) && early_q;
        state_dbg = state;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            row_cnt <= '0;
            row_sum <= '0;
            acc     <= '0;
            early_q <= 1'b0;
            mode_q  <= COST_SSD;
            loff_q  <= '0;
            roff_q  <= '0;
            lf_q    <= '0;
            lb_q    <= '0;
            rf_q    <= '0;
            rb_q    <= '0;
        end else if (accept) begin
            row_cnt <= '0;
            row_sum <= '0;
            acc     <= '0;
            early_q <= 1'b0;
            mode_q  <= mode_in;
            loff_q  <= left_off_in;
            roff_q  <= right_off_in;
            lf_q    <= left_front_in;
            lb_q    <= left_back_in;
            rf_q    <= right_front_in;
            rb_q    <= right_back_in;
        end else if (state == ST_ROW) begin
            row_sum <= row_cost;
            acc     <= acc_next;
            row_cnt <= row_cnt + 1'b1;
            if (exit_hit) early_q <= 1'b1;
        end else if (state == ST_DRAIN) begin
            acc <= acc_next;
            if (exit_hit) early_q <= 1'b1;
        end
    end

endmodule
